layer_fifo: RTL and testbench
=============================

# layer_fifo

Inter-layer buffer between a conv stage and the next one. It takes each output pixel vector the upstream stage produces (`o_data`/`o_valid`) and stores it in a synchronous FIFO. It hands pixels to the downstream line buffer through its `fifo_rd_en` / `i_valid` handshake. Its `almost_full` output drives the upstream stage's `fifo_almost_full` input, so the upstream stage stalls before words in its PE pipeline can overflow the buffer.

## Interface
- `DATA_WIDTH`, 16: bits per channel value (fixed-point, opaque here).
- `CHANNEL`, 8: channels per pixel; word width W = DATA_WIDTH*CHANNEL.
- `DEPTH`, 512: number of words; must be a power of two, ≥ 4.
- `ALMOST_FULL_SPACE`, 8: free-slot threshold. Must exceed the upstream pipeline latency in words; legal range 1..DEPTH-1.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_data`  in  W  write word (upstream `o_data`).
- `i_valid`  in  1  write request (upstream `o_valid`).
- `rd_en`  in  1  read request (downstream `fifo_rd_en`).
- `o_data`  out  W  read word, registered.
- `o_valid`  out  1  `o_data` valid this cycle (downstream `i_valid`).
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count ≥ DEPTH − ALMOST_FULL_SPACE.
- `count`  out  clog2(DEPTH)+1  words stored.
- `overflow`  out  1  sticky: a write was dropped.

## Operation
- State: write pointer `wp`, read pointer `rp`, each clog2(DEPTH) bits and wrapping modulo DEPTH. `count` is a separate register.
- Write accept: `wr_ok = i_valid & ~full`, with `full` as registered at the start of the cycle. On accept, `mem[wp] <= i_data` and `wp` increments.
- Write drop: `i_valid & full` drops the word and sets `overflow`. `overflow` clears only on `rst`.
- Read accept: `rd_ok = rd_en & ~empty`, with `empty` as registered at the start of the cycle. On accept, `o_data <= mem[rp]`, `rp` increments, and `o_valid <= 1`. Otherwise `o_valid <= 0` and `o_data` holds its value.
- `rd_en` while empty is ignored. No error flag is raised.
- No write-to-read bypass: a word written in cycle t is readable from cycle t+1 at the earliest.
- Count update: `count_next = count + wr_ok − rd_ok`.
- All of `empty`, `full`, `almost_full` and `count` are registered from `count_next`, so they are mutually consistent every cycle.
- Simultaneous events:
  - Full, with `i_valid` and `rd_en` both high: the read succeeds, the write is dropped, `overflow` sets, and count becomes DEPTH−1.
  - Empty, with both high: the write succeeds, the read is ignored, and count becomes 1.
  - Otherwise, both high: both succeed and count is unchanged.
- Reset values: `wp = rp = 0`, `count = 0`, `empty = 1`, `full = 0`, `almost_full = 0`, `overflow = 0`, `o_valid = 0`, `o_data = 0`. Memory contents are not reset.
- Reset mid-operation discards all stored words immediately. Any write or read in the reset-release cycle follows the normal rules from the empty state.

## Timing
- Read latency is 1 cycle: `rd_en` accepted at edge t means `o_valid`/`o_data` are valid during cycle t+1.
- Write-to-visible latency is 1 cycle: `empty` deasserts the cycle after the first accepted write.
- Flags update on the same edge as the write or read that changes them. `almost_full` asserts on the edge where count reaches DEPTH − ALMOST_FULL_SPACE.
- Sustained throughput is one write and one read per cycle.
- Memory is a simple dual-port RAM with a registered read port, suitable for block-RAM inference. It has no combinational paths from inputs to outputs.

## Structure
- Shared package holds the `clog2` function and the pointer/count width constants derived from DEPTH.
- One sub-module, `fifo_ram`:
  - Parameters W and DEPTH.
  - One write port (`we`, `waddr`, `wdata`).
  - One read port (`re`, `raddr`) with a registered `rdata`.
- Control logic (pointers, count, flags, `overflow`, `o_valid`) lives in `layer_fifo`.

## Test plan
All scenarios run with DEPTH=8, ALMOST_FULL_SPACE=2, CHANNEL=1, DATA_WIDTH=16.
- **Reset:** assert `rst` mid-cycle → all outputs are immediately at their reset values, with `empty=1` and `count=0`.
- **Fill:** write 0x0001..0x0006 → `almost_full` rises on the edge count becomes 6. Write 0x0007 and 0x0008 → `full=1`. Write 0x0009 → dropped, `overflow=1`, count stays 8.
- **Drain:** from full, hold `rd_en` for 9 cycles → `o_data` returns 0x0001..0x0008 on consecutive cycles, each one cycle after its `rd_en`. The 9th request gives `o_valid=0`, and `empty=1`.
- **Simultaneous:**
  - Full with both `i_valid` and `rd_en` high → count becomes 7 and the write is dropped.
  - Empty with both high → count becomes 1 and `o_valid=0` next cycle.
  - Count 4 with both high → count stays 4.
- **Wrap-around:** 20 words streamed at one write and one read per cycle → output sequence equals input sequence with no gaps, and count ≤ 1 throughout.
- **Mid-operation reset:** count 5 → pulse `rst` → count 0. Write 0xAAAA then read → returns 0xAAAA, not stale data.

Source files
------------

// File: rtl/layer_fifo_pkg.sv
// Shared helpers for the inter-layer FIFO: log2 and width derivations from DEPTH.
package layer_fifo_pkg;

  // Ceiling log2, usable in constant expressions (parameter and port widths).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Pointer width: addresses 0..DEPTH-1, wrapping naturally modulo DEPTH.
  function automatic int ptr_width(input int depth);
    return clog2(depth);
  endfunction

  // Count width: one extra bit so the value DEPTH itself is representable.
  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with one write port and a registered read port.
// Only the read register is reset; the array itself is left uninitialised.
module fifo_ram
  import layer_fifo_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ptr_width(DEPTH)-1:0] waddr,
  input  logic [W-1:0]                wdata,
  input  logic                        re,
  input  logic [ptr_width(DEPTH)-1:0] raddr,
  output logic [W-1:0]                rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_d;
  logic [W-1:0] rdata_q;

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port next value: fetch on a read, otherwise hold the last word.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read output register, cleared on reset so the FIFO output starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/layer_fifo.sv
// Inter-layer buffer between conv stages: synchronous FIFO with registered
// flags, a sticky overflow indicator and an almost-full early warning that
// throttles the upstream PE pipeline.
module layer_fifo
  import layer_fifo_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int CHANNEL           = 8,
  parameter int DEPTH             = 512,
  parameter int ALMOST_FULL_SPACE = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DATA_WIDTH*CHANNEL-1:0]       i_data,
  input  logic                                i_valid,
  input  logic                                rd_en,
  output logic [DATA_WIDTH*CHANNEL-1:0]       o_data,
  output logic                                o_valid,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_full,
  output logic [cnt_width(DEPTH)-1:0]         count,
  output logic                                overflow
);

  localparam int W  = DATA_WIDTH * CHANNEL;
  localparam int AW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic          wr_ok;
  logic          rd_ok;
  logic [AW-1:0] wp_d, wp_q;
  logic [AW-1:0] rp_d, rp_q;
  logic [CW-1:0] count_d, count_q;
  logic          empty_d, empty_q;
  logic          full_d, full_q;
  logic          almost_full_d, almost_full_q;
  logic          overflow_d, overflow_q;
  logic          o_valid_d, o_valid_q;

  // Accept decisions use the flags as registered at the start of the cycle,
  // so a full FIFO drops a write even when a read frees a slot on the same edge.
  always_comb begin
    wr_ok         = i_valid & ~full_q;
    rd_ok         = rd_en & ~empty_q;
    wp_d          = wr_ok ? wp_q + AW'(1) : wp_q;
    rp_d          = rd_ok ? rp_q + AW'(1) : rp_q;
    count_d       = count_q + CW'(wr_ok) - CW'(rd_ok);
    empty_d       = (count_d == '0);
    full_d        = (count_d == CW'(DEPTH));
    almost_full_d = (count_d >= CW'(DEPTH - ALMOST_FULL_SPACE));
    overflow_d    = overflow_q | (i_valid & full_q);
    o_valid_d     = rd_ok;
  end

  // Control state: pointers, occupancy and flags all follow count_d together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      o_valid_q     <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      o_valid_q     <= o_valid_d;
    end
  end

  fifo_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wp_q),
    .wdata (i_data),
    .re    (rd_ok),
    .raddr (rp_q),
    .rdata (o_data)
  );

  assign o_valid     = o_valid_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign count       = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_layer_fifo.sv
// Self-checking bench for layer_fifo with DEPTH=8, ALMOST_FULL_SPACE=2.
// Read data is checked by a monitor against a queue of expected words;
// occupancy and flags are checked against hand-computed constants.
module tb_layer_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AFS   = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          rd_en;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [3:0]    count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] stored[$];
  logic [DW-1:0] expQ[$];

  layer_fifo #(
    .DATA_WIDTH        (DW),
    .CHANNEL           (1),
    .DEPTH             (DEPTH),
    .ALMOST_FULL_SPACE (AFS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .rd_en       (rd_en),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of write/read requests; on accepted reads, push the word
  // that should appear on o_data one cycle later into the expected queue.
  task automatic applyStimulus(input logic wr, input logic [DW-1:0] d, input logic rd);
    bit acceptRd;
    bit acceptWr;
    @(negedge clk);
    i_valid = wr;
    i_data  = d;
    rd_en   = rd;
    acceptRd = rd && (stored.size() > 0);
    acceptWr = wr && (stored.size() < DEPTH);
    if (acceptRd) expQ.push_back(stored.pop_front());
    if (acceptWr) stored.push_back(d);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    rd_en   = 1'b0;
  endtask

  // Monitor: every presented output word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_read: got o_data %0h with no read outstanding", o_data);
      end else begin
        logic [DW-1:0] want;
        want = expQ.pop_front();
        if (o_data !== want) begin
          errors++;
          $display("[TB] FAIL read_data: got %0h, expected %0h", o_data, want);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    rd_en   = 1'b0;

    // Reset values, sampled mid-cycle while reset is held.
    #12;
    checkOutput("reset_empty", int'(empty), 1);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_full", int'(full), 0);
    checkOutput("reset_almost_full", int'(almost_full), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_o_valid", int'(o_valid), 0);
    checkOutput("reset_o_data", int'(o_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill: almost_full rises when count reaches 6, full at 8.
    for (int v = 1; v <= 8; v++) begin
      applyStimulus(1'b1, DW'(v), 1'b0);
      checkOutput("fill_count", int'(count), v);
      checkOutput("fill_almost_full", int'(almost_full), (v >= 6) ? 1 : 0);
      checkOutput("fill_full", int'(full), (v == 8) ? 1 : 0);
      checkOutput("fill_empty", int'(empty), 0);
    end
    checkOutput("pre_overflow", int'(overflow), 0);
    applyStimulus(1'b1, 16'h0009, 1'b0);
    checkOutput("drop_overflow", int'(overflow), 1);
    checkOutput("drop_count", int'(count), 8);
    checkOutput("drop_full", int'(full), 1);

    // Drain: eight words out back to back, the ninth request is ignored.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (i < 8) begin
        checkOutput("drain_o_valid", int'(o_valid), 1);
        checkOutput("drain_count", int'(count), 7 - i);
      end else begin
        checkOutput("drain_extra_o_valid", int'(o_valid), 0);
        checkOutput("drain_empty", int'(empty), 1);
        checkOutput("drain_count_zero", int'(count), 0);
      end
    end

    // Full with write and read together: read wins, write dropped.
    for (int v = 0; v < 8; v++) applyStimulus(1'b1, 16'h0011 + DW'(v), 1'b0);
    checkOutput("refill_full", int'(full), 1);
    applyStimulus(1'b1, 16'h0099, 1'b1);
    checkOutput("sim_full_count", int'(count), 7);
    checkOutput("sim_full_full", int'(full), 0);
    checkOutput("sim_full_overflow", int'(overflow), 1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("sim_full_drained", int'(count), 0);

    // Empty with write and read together: write accepted, read ignored.
    applyStimulus(1'b1, 16'h0055, 1'b1);
    checkOutput("sim_empty_count", int'(count), 1);
    checkOutput("sim_empty_o_valid", int'(o_valid), 0);
    checkOutput("sim_empty_empty", int'(empty), 0);

    // Count 4 with write and read together: count unchanged.
    for (int v = 0; v < 3; v++) applyStimulus(1'b1, 16'h0056 + DW'(v), 1'b0);
    checkOutput("mid_count_before", int'(count), 4);
    applyStimulus(1'b1, 16'h0059, 1'b1);
    checkOutput("mid_count_after", int'(count), 4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("mid_drained", int'(count), 0);

    // Wrap-around stream: one write and one read per cycle, no gaps.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'h0100 + DW'(i), (i > 0));
      checkOutput("stream_count", int'(count), 1);
      if (i > 0) checkOutput("stream_o_valid", int'(o_valid), 1);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("stream_tail_o_valid", int'(o_valid), 1);
    checkOutput("stream_empty", int'(empty), 1);

    // Mid-operation reset discards contents and clears sticky overflow.
    for (int v = 0; v < 5; v++) applyStimulus(1'b1, 16'h0200 + DW'(v), 1'b0);
    checkOutput("prereset_count", int'(count), 5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset_count", int'(count), 0);
    checkOutput("midreset_empty", int'(empty), 1);
    checkOutput("midreset_overflow", int'(overflow), 0);
    checkOutput("midreset_o_data", int'(o_data), 0);
    checkOutput("midreset_almost_full", int'(almost_full), 0);
    stored.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 16'hAAAA, 1'b0);
    checkOutput("postreset_count", int'(count), 1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("postreset_o_valid", int'(o_valid), 1);
    checkOutput("postreset_o_data", int'(o_data), 16'hAAAA);

    // Every expected read must have been consumed by the monitor.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pending_reads", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
